// File: rtl/ring_buffer_ctrl_if.sv
// Producer/consumer handshakes, ring-buffer drive lines and occupancy status
// seen by ring_buffer_ctrl.
interface ring_buffer_ctrl_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0][DATA_W-1:0] req_data;
    logic [N_REQ-1:0]             req_ready;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    logic              rb_enable;
    logic              rb_push;
    logic              rb_pop;
    logic [DATA_W-1:0] rb_datain;
    logic [DATA_W-1:0] rb_dataout;

    logic [3:0] count;
    logic       full;
    logic       empty;

    modport master (
        input  req_valid, req_data, out_ready, rb_dataout,
        output req_ready, out_valid, out_data,
        output rb_enable, rb_push, rb_pop, rb_datain,
        output count, full, empty
    );

    modport slave (
        output req_valid, req_data, out_ready, rb_dataout,
        input  req_ready, out_valid, out_data,
        input  rb_enable, rb_push, rb_pop, rb_datain,
        input  count, full, empty
    );
endinterface

// File: rtl/ring_buffer_ctrl.sv
// Round-robin write arbiter, push/pop scheduler and output register in front
// of a flagless ring buffer whose pop data arrives one cycle after the pop.

// Per-producer lane: flags a request at or above the round-robin pointer.
module ring_buffer_lane #(
    parameter int LANE  = 0,
    parameter int PTR_W = 2
) (
    input  logic             valid,
    input  logic [PTR_W-1:0] ptr,
    output logic             hi
);
    assign hi = valid && (PTR_W'(LANE) >= ptr);
endmodule

module ring_buffer_ctrl #(
    parameter int N_REQ  = 4,
    parameter int DEPTH  = 10,
    parameter int DATA_W = 8
) (
    input  logic           clock,
    input  logic           reset,
    ring_buffer_ctrl_if.master bus
);
    localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int STAGES = 1;

    typedef enum logic {OP_POP = 1'b0, OP_PUSH = 1'b1} op_e;

    op_e               last_op, last_op_nxt;
    logic [3:0]        count_q;
    logic              full_q, empty_q;
    logic [PTR_W-1:0]  rr_ptr, gnt_idx;
    logic [N_REQ-1:0]  hi_mask, sel_mask;
    logic              push_cand, pop_elig, do_push, do_pop;
    logic [STAGES:0]   vld_pipe;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        ring_buffer_lane #(.LANE(i), .PTR_W(PTR_W)) u_lane (
            .valid (bus.req_valid[i]),
            .ptr   (rr_ptr),
            .hi    (hi_mask[i])
        );
    end

    // Requests at/above the pointer win; otherwise wrap to the lowest index.
    always_comb begin
        sel_mask = (|hi_mask) ? hi_mask : bus.req_valid;
        gnt_idx  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (sel_mask[i]) gnt_idx = PTR_W'(i);
        end
    end

    assign push_cand = !reset && (|bus.req_valid) && !full_q;
    assign pop_elig  = !reset && !empty_q && !vld_pipe[STAGES]
                     && (!out_valid_q || bus.out_ready);

    // Scheduler state: the last issued op decides who wins under contention.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) last_op <= OP_POP;
        else       last_op <= last_op_nxt;
    end

    always_comb begin
        do_push     = push_cand && (!pop_elig || last_op == OP_POP);
        do_pop      = pop_elig && !do_push;
        last_op_nxt = last_op;
        if (do_push)     last_op_nxt = OP_PUSH;
        else if (do_pop) last_op_nxt = OP_POP;
    end

    always_comb begin
        bus.req_ready = '0;
        if (do_push) bus.req_ready[gnt_idx] = 1'b1;
        bus.rb_push   = do_push;
        bus.rb_pop    = do_pop;
        bus.rb_enable = do_push || do_pop;
        bus.rb_datain = do_push ? bus.req_data[gnt_idx] : '0;
    end

    // Occupancy drops at pop issue, not when the byte reaches the consumer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            rr_ptr  <= '0;
        end else if (do_push) begin
            count_q <= count_q + 4'd1;
            full_q  <= (count_q == 4'(DEPTH - 1));
            empty_q <= 1'b0;
            rr_ptr  <= (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (do_pop) begin
            count_q <= count_q - 4'd1;
            full_q  <= 1'b0;
            empty_q <= (count_q == 4'd1);
        end
    end

    assign vld_pipe[0] = do_pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) vld_pipe[STAGES:1] <= '0;
        else       vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    // A capture may coincide with a handshake; the new byte simply replaces it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (vld_pipe[STAGES]) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.rb_dataout;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.count     = count_q;
    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_ring_buffer_ctrl.sv
// Randomized scoreboard bench for ring_buffer_ctrl with a queue model of the
// ring buffer and of the scheduling/arbitration rules.
module tb_ring_buffer_ctrl;
    localparam int N     = 4;
    localparam int DEPTH = 10;
    localparam int W     = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    ring_buffer_ctrl_if #(.N_REQ(N), .DATA_W(W)) bus();

    ring_buffer_ctrl #(.N_REQ(N), .DEPTH(DEPTH), .DATA_W(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [N-1:0]        prod_valid = '0;
    logic [N-1:0][W-1:0] prod_data  = '0;
    assign bus.req_valid = prod_valid;
    assign bus.req_data  = prod_data;

    int n_checks = 0;
    int n_err    = 0;

    // Reference state: buffer contents, expected consumer stream, rule state.
    logic [W-1:0] rbq[$];
    logic [W-1:0] sb[$];
    int           rr_ref       = 0;
    bit           last_push    = 1'b0;
    bit           inflight_ref = 1'b0;
    bit           ov_ref       = 1'b0;

    bit           s_push, s_pop, s_hand;
    int           s_g;
    bit           prev_hold = 1'b0;
    logic [W-1:0] prev_data;
    logic [N-1:0] acc_mask = '0;
    bit           pop_seen = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / checker, mid-cycle.
    always @(negedge clock) begin
        int occ, g, idx;
        bit cand, elig, ep, eq;
        s_push = 1'b0;
        s_pop  = 1'b0;
        s_hand = 1'b0;
        s_g    = 0;
        if (reset) begin
            chk("rst_count", int'(bus.count), 0);
            chk("rst_empty", int'(bus.empty), 1);
            chk("rst_full", int'(bus.full), 0);
            chk("rst_out_valid", int'(bus.out_valid), 0);
            chk("rst_out_data", int'(bus.out_data), 0);
            chk("rst_req_ready", int'(bus.req_ready), 0);
            chk("rst_rb_enable", int'(bus.rb_enable), 0);
            chk("rst_rb_datain", int'(bus.rb_datain), 0);
            prev_hold = 1'b0;
        end else begin
            occ = rbq.size();
            chk("count", int'(bus.count), occ);
            chk("full", int'(bus.full), int'(occ == DEPTH));
            chk("empty", int'(bus.empty), int'(occ == 0));
            chk("out_valid", int'(bus.out_valid), int'(ov_ref));

            g = -1;
            for (int k = 0; k < N; k++) begin
                idx = (rr_ref + k) % N;
                if (g < 0 && prod_valid[idx]) g = idx;
            end
            cand = (g >= 0) && (occ < DEPTH);
            elig = (occ > 0) && !inflight_ref && (!ov_ref || bus.out_ready);
            ep   = cand && (!elig || !last_push);
            eq   = elig && !ep;
            chk("rb_push", int'(bus.rb_push), int'(ep));
            chk("rb_pop", int'(bus.rb_pop), int'(eq));
            chk("rb_enable", int'(bus.rb_enable), int'(ep || eq));
            chk("req_ready", int'(bus.req_ready), ep ? (1 << g) : 0);
            if (ep) chk("rb_datain", int'(bus.rb_datain), int'(prod_data[g]));

            if (prev_hold) begin
                chk("hold_valid", int'(bus.out_valid), 1);
                chk("hold_data", int'(bus.out_data), int'(prev_data));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL out_data: got %0d with no byte expected at %0t",
                             bus.out_data, $time);
                end else begin
                    chk("out_data", int'(bus.out_data), int'(sb.pop_front()));
                end
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;

            s_push = ep;
            s_pop  = eq;
            s_g    = (g < 0) ? 0 : g;
            s_hand = ov_ref && bus.out_ready;
        end
    end

    // Ring buffer model and rule-state update at the active edge.
    always @(posedge clock) begin
        acc_mask = '0;
        pop_seen = 1'b0;
        if (reset) begin
            rbq.delete();
            sb.delete();
            rr_ref       = 0;
            last_push    = 1'b0;
            inflight_ref = 1'b0;
            ov_ref       = 1'b0;
            bus.rb_dataout <= '0;
        end else begin
            if (inflight_ref) ov_ref = 1'b1;
            else if (s_hand)  ov_ref = 1'b0;
            inflight_ref = s_pop;
            if (s_push) begin
                rbq.push_back(prod_data[s_g]);
                sb.push_back(prod_data[s_g]);
                rr_ref      = (s_g + 1) % N;
                last_push   = 1'b1;
                acc_mask[s_g] = 1'b1;
            end else if (s_pop) begin
                bus.rb_dataout <= rbq.pop_front();
                last_push = 1'b0;
                pop_seen  = 1'b1;
            end
        end
    end

    // One cycle of producer/consumer activity; accepted producers retire
    // their byte, held producers keep it unchanged.
    task automatic step(input int p_new, input logic [N-1:0] en, input int p_rdy,
                        input bit fixed);
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_mask[i] || !en[i]) prod_valid[i] = 1'b0;
            if (!prod_valid[i] && en[i] && ($urandom_range(99) < p_new)) begin
                prod_valid[i] = 1'b1;
                prod_data[i]  = fixed ? W'(8'hA0 + i) : W'($urandom);
            end
        end
        bus.out_ready = ($urandom_range(99) < p_rdy);
    endtask

    initial begin
        bit done;
        bus.out_ready = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // single byte 0x11 from requester 0
        prod_data[0]  = 8'h11;
        prod_valid[0] = 1'b1;
        repeat (8) step(0, 4'b0001, 100, 1'b0);

        // all requesters, fixed 0xA0..0xA3, consumer stalled until full
        repeat (20) step(100, 4'b1111, 0, 1'b1);
        repeat (40) step(100, 4'b1111, 100, 1'b1);

        // single requester against a ready consumer: push/pop alternate
        repeat (40) step(100, 4'b0100, 100, 1'b0);

        // consumer back-pressure
        repeat (40) step(60, 4'b1111, 20, 1'b0);

        // randomized mixes
        for (int ph = 0; ph < 15; ph++) begin
            int pn, pr;
            logic [N-1:0] en;
            pn = $urandom_range(100);
            pr = $urandom_range(100);
            en = N'($urandom);
            repeat (100) step(pn, en, pr, 1'b0);
        end

        // reset during the capture cycle of a pop
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            step(50, 4'b1111, 100, 1'b0);
            if (pop_seen) done = 1'b1;
        end
        chk("pop_before_reset", int'(done), 1);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // push 0x77 after reset, then read it back
        prod_valid    = '0;
        prod_data[0]  = 8'h77;
        prod_valid[0] = 1'b1;
        repeat (8) step(0, 4'b0001, 100, 1'b0);

        // requester 3 alone, then 0 and 3 together
        repeat (4) step(100, 4'b1000, 100, 1'b0);
        repeat (20) step(100, 4'b1001, 50, 1'b0);

        // drain
        repeat (60) step(0, 4'b0000, 100, 1'b0);
        @(negedge clock);
        chk("drain_sb", sb.size(), 0);
        chk("drain_count", int'(bus.count), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
